// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmit path between N_REQ byte producers.
// After reset it flushes the UART FIFOs with one CONTROL write. It then
// grants requesters round-robin, polls STATUS until Tx-Full clears, writes
// the byte to TX_FIFO and acknowledges the requester with a one-cycle pulse.
module uart_tx_sched #(
  parameter int                N_REQ     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] UART_BASE = '0,
  parameter int                POLL_GAP  = 8,
  parameter logic [31:0]       CTRL_INIT = 32'h3,
  localparam int               IDW       = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [2:0]           a_opcode,
  output logic [ADDR_W-1:0]    a_address,
  output logic [31:0]          a_data,
  input  logic                 d_valid,
  output logic                 d_ready,
  input  logic [31:0]          d_data,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam logic [2:0] OP_GET = 3'd4;
  localparam logic [2:0] OP_PUT = 3'd0;

  localparam logic [ADDR_W-1:0] ADDR_TX   = UART_BASE + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_STAT = UART_BASE + ADDR_W'(8);
  localparam logic [ADDR_W-1:0] ADDR_CTRL = UART_BASE + ADDR_W'(12);

  localparam int CNT_W = $clog2(POLL_GAP + 1);
  localparam logic [IDW:0] N_REQ_W = (IDW+1)'(N_REQ);

  localparam logic [2:0] S_INIT_REQ = 3'd0;
  localparam logic [2:0] S_INIT_RSP = 3'd1;
  localparam logic [2:0] S_IDLE     = 3'd2;
  localparam logic [2:0] S_STAT_REQ = 3'd3;
  localparam logic [2:0] S_STAT_RSP = 3'd4;
  localparam logic [2:0] S_BACKOFF  = 3'd5;
  localparam logic [2:0] S_WR_REQ   = 3'd6;
  localparam logic [2:0] S_WR_RSP   = 3'd7;

  logic [2:0]        state_reg, state_next;
  logic [IDW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]    grant_id_reg, grant_id_next;
  logic [7:0]        byte_reg, byte_next;
  logic [N_REQ-1:0]  req_ready_reg, req_ready_next;
  logic              a_valid_reg, a_valid_next;
  logic [2:0]        a_opcode_reg, a_opcode_next;
  logic [ADDR_W-1:0] a_address_reg, a_address_next;
  logic [31:0]       a_data_reg, a_data_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic [IDW:0]      scan_sum;
  logic [IDW-1:0]    scan_idx;

  // Only Tx-Full is meaningful in the STATUS word.
  logic unused_d_data;
  assign unused_d_data = ^{d_data[31:4], d_data[2:0]};

  // Round-robin pick: scan downward in offset so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
      if (scan_sum >= N_REQ_W) scan_sum = scan_sum - N_REQ_W;
      scan_idx = scan_sum[IDW-1:0];
      if (req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Next-state and bus-request launch logic; request fields are set on entry to a *_REQ state.
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_id_next  = grant_id_reg;
    byte_next      = byte_reg;
    req_ready_next = '0;
    a_valid_next   = a_valid_reg;
    a_opcode_next  = a_opcode_reg;
    a_address_next = a_address_reg;
    a_data_next    = a_data_reg;
    cnt_next       = cnt_reg;
    case (state_reg)
      S_INIT_REQ: begin
        if (!a_valid_reg) begin
          // First cycle out of reset: present the FIFO flush write.
          a_valid_next   = 1'b1;
          a_opcode_next  = OP_PUT;
          a_address_next = ADDR_CTRL;
          a_data_next    = CTRL_INIT;
        end else if (a_ready) begin
          a_valid_next = 1'b0;
          state_next   = S_INIT_RSP;
        end
      end
      S_INIT_RSP: begin
        if (d_valid) state_next = S_IDLE;
      end
      S_IDLE: begin
        // Hold off while an acknowledge is on the wire so the acked byte is not regranted.
        if (pick_found && (req_ready_reg == '0)) begin
          grant_id_next  = pick_idx;
          byte_next      = req_data[{pick_idx, 3'b000} +: 8];
          a_valid_next   = 1'b1;
          a_opcode_next  = OP_GET;
          a_address_next = ADDR_STAT;
          a_data_next    = '0;
          state_next     = S_STAT_REQ;
        end
      end
      S_STAT_REQ: begin
        if (a_ready) begin
          a_valid_next = 1'b0;
          state_next   = S_STAT_RSP;
        end
      end
      S_STAT_RSP: begin
        if (d_valid) begin
          if (d_data[3]) begin
            cnt_next   = CNT_W'(POLL_GAP - 1);
            state_next = S_BACKOFF;
          end else begin
            a_valid_next   = 1'b1;
            a_opcode_next  = OP_PUT;
            a_address_next = ADDR_TX;
            a_data_next    = {24'b0, byte_reg};
            state_next     = S_WR_REQ;
          end
        end
      end
      S_BACKOFF: begin
        if (cnt_reg == '0) begin
          a_valid_next   = 1'b1;
          a_opcode_next  = OP_GET;
          a_address_next = ADDR_STAT;
          a_data_next    = '0;
          state_next     = S_STAT_REQ;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_WR_REQ: begin
        if (a_ready) begin
          a_valid_next = 1'b0;
          state_next   = S_WR_RSP;
        end
      end
      S_WR_RSP: begin
        if (d_valid) begin
          req_ready_next[grant_id_reg] = 1'b1;
          rr_ptr_next = (grant_id_reg == IDW'(N_REQ - 1)) ? '0 : grant_id_reg + IDW'(1);
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_INIT_REQ;
    endcase
  end

  // State registers; reset aborts any transfer and restarts with the flush write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_INIT_REQ;
      rr_ptr_reg    <= '0;
      grant_id_reg  <= '0;
      byte_reg      <= '0;
      req_ready_reg <= '0;
      a_valid_reg   <= 1'b0;
      a_opcode_reg  <= OP_PUT;
      a_address_reg <= ADDR_CTRL;
      a_data_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_id_reg  <= grant_id_next;
      byte_reg      <= byte_next;
      req_ready_reg <= req_ready_next;
      a_valid_reg   <= a_valid_next;
      a_opcode_reg  <= a_opcode_next;
      a_address_reg <= a_address_next;
      a_data_reg    <= a_data_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign req_ready = req_ready_reg;
  assign a_valid   = a_valid_reg;
  assign a_opcode  = a_opcode_reg;
  assign a_address = a_address_reg;
  assign a_data    = a_data_reg;
  assign grant_id  = grant_id_reg;
  assign d_ready   = (state_reg == S_INIT_RSP) || (state_reg == S_STAT_RSP) ||
                     (state_reg == S_WR_RSP);
  assign busy      = (state_reg != S_IDLE);

endmodule
